// File: rtl/ram_b1_ctrl.sv
// Beta-RAM B1 burst controller: independent write and read burst FSMs driving registered RAM controls.
// Optional macro B1_HAZARD_CHECK_EN holds a read off a layer until the in-flight write to it completes.
module ram_b1_ctrl #(
    parameter int AW = 9,
    parameter int LW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_req,
    input  logic [LW-1:0] wr_layer,
    input  logic [AW-1:0] wr_base,
    input  logic          rd_req,
    input  logic [LW-1:0] rd_layer,
    input  logic [AW-1:0] rd_base,
    output logic          wr_ready,
    output logic          rd_ready,
    output logic          w_en,
    output logic [LW-1:0] layer_w,
    output logic [AW-1:0] w_address,
    output logic [3:0]    cnta,
    output logic          r_en,
    output logic [LW-1:0] layer_r,
    output logic [AW-1:0] r_address,
    output logic [3:0]    cntb,
    output logic          rd_valid,
    output logic          rd_last,
    output logic          wr_done,
    output logic          req_err
);
    typedef enum logic {W_IDLE, W_BURST} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;

    w_state_t      w_state, w_state_n;
    r_state_t      r_state, r_state_n;
    logic [3:0]    w_len, w_len_n, r_len, r_len_n;
    logic          r_last, r_last_n;   // current read beat is the final one
    logic          w_en_n, wr_done_n, r_en_n, rd_valid_n, rd_last_n, req_err_n;
    logic [3:0]    cnta_n, cntb_n;
    logic [LW-1:0] layer_w_n, layer_r_n;
    logic [AW-1:0] w_address_n, r_address_n;
    logic          wr_acc, rd_acc, wr_legal, rd_legal, rd_hazard;

    function automatic logic layer_legal(input logic [LW-1:0] layer);
        return (layer != '0) && (layer <= LW'(8));
    endfunction

    function automatic logic [3:0] burst_len(input logic [LW-1:0] layer);
        if (layer == LW'(8)) return 4'd4;
        if (layer == LW'(7)) return 4'd2;
        return 4'd1;
    endfunction

    assign wr_ready = (w_state == W_IDLE);
    assign rd_ready = (r_state == R_IDLE);
    assign wr_acc   = wr_req && wr_ready;
    assign rd_acc   = rd_req && rd_ready;
    assign wr_legal = layer_legal(wr_layer);
    assign rd_legal = layer_legal(rd_layer);

`ifdef B1_HAZARD_CHECK_EN
    // A write still owning the layer (not on its final beat) or starting on it this edge blocks the read.
    assign rd_hazard = ((w_state == W_BURST) && !wr_done && (layer_w == rd_layer))
                    || (wr_acc && wr_legal && (wr_layer == rd_layer));
`else
    assign rd_hazard = 1'b0;
`endif

    always_comb begin
        // NOTE: every next value gets a default first so no path through the case infers a latch.
        w_state_n   = w_state;
        w_en_n      = 1'b0;
        cnta_n      = 4'd0;
        wr_done_n   = 1'b0;
        layer_w_n   = layer_w;
        w_address_n = w_address;
        w_len_n     = w_len;
        unique case (w_state)
            W_IDLE: begin
                if (wr_acc && wr_legal) begin
                    w_state_n   = W_BURST;
                    w_en_n      = 1'b1;
                    layer_w_n   = wr_layer;
                    w_address_n = wr_base;
                    w_len_n     = burst_len(wr_layer);
                    wr_done_n   = (burst_len(wr_layer) == 4'd1);
                end
            end
            W_BURST: begin
                if (wr_done) begin
                    w_state_n = W_IDLE;
                end else begin
                    w_en_n    = 1'b1;
                    cnta_n    = cnta + 4'd1;
                    wr_done_n = (cnta + 4'd2 == w_len);
                end
            end
        endcase
    end

    always_comb begin
        r_state_n   = r_state;
        r_en_n      = 1'b0;
        cntb_n      = 4'd0;
        r_last_n    = 1'b0;
        layer_r_n   = layer_r;
        r_address_n = r_address;
        r_len_n     = r_len;
        case (r_state)
            R_IDLE: begin
                if (rd_acc && rd_legal) begin
                    layer_r_n   = rd_layer;
                    r_address_n = rd_base;
                    r_len_n     = burst_len(rd_layer);
                    if (rd_hazard) begin
                        r_state_n = R_WAIT;
                    end else begin
                        r_state_n = R_BURST;
                        r_en_n    = 1'b1;
                        r_last_n  = (burst_len(rd_layer) == 4'd1);
                    end
                end
            end
            R_WAIT: begin
                if (wr_done) begin
                    r_state_n = R_BURST;
                    r_en_n    = 1'b1;
                    r_last_n  = (r_len == 4'd1);
                end
            end
            R_BURST: begin
                if (r_last) begin
                    r_state_n = R_IDLE;
                end else begin
                    r_en_n   = 1'b1;
                    cntb_n   = cntb + 4'd1;
                    r_last_n = (cntb + 4'd2 == r_len);
                end
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    // The RAM read data appears one cycle after r_en, so valid/last trail the read beats.
    assign rd_valid_n = r_en;
    assign rd_last_n  = r_en && r_last;
    assign req_err_n  = (wr_acc && !wr_legal) || (rd_acc && !rd_legal);

    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state   <= W_IDLE;
            r_state   <= R_IDLE;
            w_len     <= 4'd0;
            r_len     <= 4'd0;
            r_last    <= 1'b0;
            w_en      <= 1'b0;
            cnta      <= 4'd0;
            wr_done   <= 1'b0;
            layer_w   <= '0;
            w_address <= '0;
            r_en      <= 1'b0;
            cntb      <= 4'd0;
            layer_r   <= '0;
            r_address <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            req_err   <= 1'b0;
        end else begin
            w_state   <= w_state_n;
            r_state   <= r_state_n;
            w_len     <= w_len_n;
            r_len     <= r_len_n;
            r_last    <= r_last_n;
            w_en      <= w_en_n;
            cnta      <= cnta_n;
            wr_done   <= wr_done_n;
            layer_w   <= layer_w_n;
            w_address <= w_address_n;
            r_en      <= r_en_n;
            cntb      <= cntb_n;
            layer_r   <= layer_r_n;
            r_address <= r_address_n;
            rd_valid  <= rd_valid_n;
            rd_last   <= rd_last_n;
            req_err   <= req_err_n;
        end
    end
endmodule

// File: tb/tb_ram_b1_ctrl.sv
// Bench for ram_b1_ctrl: directed bursts plus randomized traffic against a cycle-window model.
module tb_ram_b1_ctrl;
    localparam int AW = 9;
    localparam int LW = 5;
`ifdef B1_HAZARD_CHECK_EN
    localparam bit HAZ = 1'b1;
`else
    localparam bit HAZ = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_req = 1'b0;
    logic [LW-1:0] wr_layer = '0;
    logic [AW-1:0] wr_base = '0;
    logic          rd_req = 1'b0;
    logic [LW-1:0] rd_layer = '0;
    logic [AW-1:0] rd_base = '0;
    logic          wr_ready, rd_ready, w_en, r_en, rd_valid, rd_last, wr_done, req_err;
    logic [LW-1:0] layer_w, layer_r;
    logic [AW-1:0] w_address, r_address;
    logic [3:0]    cnta, cntb;

    ram_b1_ctrl #(.AW(AW), .LW(LW)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_layer(wr_layer), .wr_base(wr_base),
        .rd_req(rd_req), .rd_layer(rd_layer), .rd_base(rd_base),
        .wr_ready(wr_ready), .rd_ready(rd_ready),
        .w_en(w_en), .layer_w(layer_w), .w_address(w_address), .cnta(cnta),
        .r_en(r_en), .layer_r(layer_r), .r_address(r_address), .cntb(cntb),
        .rd_valid(rd_valid), .rd_last(rd_last), .wr_done(wr_done), .req_err(req_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // Model: each burst is a window of cycle numbers [start, end]; outputs follow from membership.
    bit w_valid = 1'b0;
    bit r_valid = 1'b0;
    int w_start = 0, w_end = 0, w_layer_m = 0, w_base_m = 0;
    int r_acc = 0, r_start = 0, r_end = 0, r_layer_m = 0, r_base_m = 0;
    int err_cycle = -1;

    function automatic bit legal(input int l);
        return (l >= 1) && (l <= 8);
    endfunction

    function automatic int blen(input int l);
        return (l == 8) ? 4 : (l == 7) ? 2 : 1;
    endfunction

    function automatic bit m_w_en(input int t);
        return w_valid && (t >= w_start) && (t <= w_end);
    endfunction

    function automatic bit m_r_en(input int t);
        return r_valid && (t >= r_start) && (t <= r_end);
    endfunction

    function automatic bit m_rd_ready(input int t);
        return !(r_valid && (t >= r_acc + 1) && (t <= r_end));
    endfunction

    task automatic model_reset();
        w_valid   = 1'b0;
        r_valid   = 1'b0;
        err_cycle = -1;
    endtask

    task automatic model_step();
        bit wr_ok;
        bit rd_ok;
        int c;
        int s;
        c = cyc;
        if (!rst) begin
            model_reset();
            return;
        end
        wr_ok = wr_req && !m_w_en(c);
        rd_ok = rd_req && m_rd_ready(c);
        if (wr_ok) begin
            if (legal(int'(wr_layer))) begin
                w_valid   = 1'b1;
                w_start   = c + 1;
                w_end     = c + blen(int'(wr_layer));
                w_layer_m = int'(wr_layer);
                w_base_m  = int'(wr_base);
            end else begin
                err_cycle = c + 1;
            end
        end
        if (rd_ok) begin
            if (legal(int'(rd_layer))) begin
                s = c + 1;
                if (HAZ && w_valid && (w_layer_m == int'(rd_layer)) && (w_end >= c))
                    s = w_end + 1;
                r_valid   = 1'b1;
                r_acc     = c;
                r_start   = s;
                r_end     = s + blen(int'(rd_layer)) - 1;
                r_layer_m = int'(rd_layer);
                r_base_m  = int'(rd_base);
            end else begin
                err_cycle = c + 1;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("wr_ready", wr_ready, !m_w_en(cyc));
            check("w_en", w_en, m_w_en(cyc));
            check("cnta", cnta, m_w_en(cyc) ? cyc - w_start : 0);
            check("wr_done", wr_done, w_valid && (cyc == w_end));
            check("rd_ready", rd_ready, m_rd_ready(cyc));
            check("r_en", r_en, m_r_en(cyc));
            check("cntb", cntb, m_r_en(cyc) ? cyc - r_start : 0);
            check("rd_valid", rd_valid, m_r_en(cyc - 1));
            check("rd_last", rd_last, r_valid && (cyc - 1 == r_end));
            check("req_err", req_err, cyc == err_cycle);
            if (m_w_en(cyc)) begin
                check("layer_w", layer_w, w_layer_m);
                check("w_address", w_address, w_base_m);
            end
            if (m_r_en(cyc)) begin
                check("layer_r", layer_r, r_layer_m);
                check("r_address", r_address, r_base_m);
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive_wr(input bit r, input int l, input int b);
        wr_req   = r;
        wr_layer = LW'(l);
        wr_base  = AW'(b);
    endtask

    task automatic drive_rd(input bit r, input int l, input int b);
        rd_req   = r;
        rd_layer = LW'(l);
        rd_base  = AW'(b);
    endtask

    task automatic idle(input int n);
        drive_wr(1'b0, 0, 0);
        drive_rd(1'b0, 0, 0);
        for (int i = 0; i < n; i++) cycle();
    endtask

    function automatic int pick_layer();
        int p;
        p = $urandom_range(0, 99);
        if (p < 40) return 8;
        if (p < 60) return 7;
        if (p < 90) return $urandom_range(1, 6);
        if (p < 95) return 0;
        return $urandom_range(9, 31);
    endfunction

    initial begin
        #1 rst = 1'b0;
        chk_en = 1'b1;
        #3;
        check("rst_wr_ready", wr_ready, 1);
        check("rst_rd_ready", rd_ready, 1);
        check("rst_w_en", w_en, 0);
        check("rst_r_en", r_en, 0);
        check("rst_req_err", req_err, 0);
        @(negedge clk);
        cycle();
        rst = 1'b1;

        // Layer 8 write burst at base 5.
        drive_wr(1'b1, 8, 5);
        cycle();
        drive_wr(1'b0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            check("wb_w_en", w_en, 1);
            check("wb_cnta", cnta, k);
            check("wb_w_address", w_address, 5);
            check("wb_layer_w", layer_w, 8);
            check("wb_wr_done", wr_done, k == 3);
            cycle();
        end
        check("wb_w_en_end", w_en, 0);
        check("wb_wr_ready_end", wr_ready, 1);

        // Layer 7 read burst at base 3.
        drive_rd(1'b1, 7, 3);
        cycle();
        drive_rd(1'b0, 0, 0);
        check("rb0_r_en", r_en, 1);
        check("rb0_cntb", cntb, 0);
        check("rb0_r_address", r_address, 3);
        check("rb0_rd_valid", rd_valid, 0);
        cycle();
        check("rb1_r_en", r_en, 1);
        check("rb1_cntb", cntb, 1);
        check("rb1_rd_valid", rd_valid, 1);
        check("rb1_rd_last", rd_last, 0);
        cycle();
        check("rb2_r_en", r_en, 0);
        check("rb2_rd_valid", rd_valid, 1);
        check("rb2_rd_last", rd_last, 1);
        cycle();
        check("rb3_rd_valid", rd_valid, 0);
        check("rb3_rd_last", rd_last, 0);

        // Concurrent write layer 8 and read layer 4.
        drive_wr(1'b1, 8, 10);
        drive_rd(1'b1, 4, 20);
        cycle();
        drive_wr(1'b0, 0, 0);
        drive_rd(1'b0, 0, 0);
        check("cc0_w_en", w_en, 1);
        check("cc0_r_en", r_en, 1);
        cycle();
        check("cc1_w_en", w_en, 1);
        check("cc1_cnta", cnta, 1);
        check("cc1_r_en", r_en, 0);
        check("cc1_rd_last", rd_last, 1);
        idle(4);

        // Same-layer read behind an active layer 8 write.
        drive_wr(1'b1, 8, 0);
        cycle();
        drive_wr(1'b0, 0, 0);
        drive_rd(1'b1, 8, 7);
        cycle();
        drive_rd(1'b0, 0, 0);
        check("hz_w1_r_en", r_en, !HAZ);
        cycle();
        cycle();
        check("hz_w3_wr_done", wr_done, 1);
        check("hz_w3_r_en", r_en, !HAZ);
        cycle();
        check("hz_after_r_en", r_en, 1);
        check("hz_after_cntb", cntb, HAZ ? 0 : 3);
        idle(6);

        // Illegal layers on both sides.
        drive_wr(1'b1, 9, 0);
        cycle();
        drive_wr(1'b0, 0, 0);
        check("ilw_req_err", req_err, 1);
        check("ilw_w_en", w_en, 0);
        check("ilw_wr_ready", wr_ready, 1);
        cycle();
        check("ilw_req_err_end", req_err, 0);
        drive_rd(1'b1, 0, 0);
        cycle();
        drive_rd(1'b0, 0, 0);
        check("ilr_req_err", req_err, 1);
        check("ilr_r_en", r_en, 0);
        cycle();

        // Reset during the second beat of a layer 8 write.
        drive_wr(1'b1, 8, 5);
        cycle();
        drive_wr(1'b0, 0, 0);
        cycle();
        check("mr_cnta_pre", cnta, 1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("mr_w_en", w_en, 0);
        check("mr_cnta", cnta, 0);
        check("mr_wr_ready", wr_ready, 1);
        check("mr_wr_done", wr_done, 0);
        cycle();
        cycle();
        rst = 1'b1;
        drive_wr(1'b1, 1, 9);
        cycle();
        drive_wr(1'b0, 0, 0);
        check("mr_first_w_en", w_en, 1);
        check("mr_first_wr_done", wr_done, 1);
        check("mr_first_w_address", w_address, 9);
        idle(2);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst = 1'b1;
            drive_wr($urandom_range(0, 99) < 60, pick_layer(), $urandom_range(0, 511));
            drive_rd($urandom_range(0, 99) < 60, pick_layer(), $urandom_range(0, 511));
            if ($urandom_range(0, 299) == 0) begin
                #1 rst = 1'b0;
                model_reset();
            end
            cycle();
        end
        rst = 1'b1;
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
